fir_serial_mac: RTL and testbench

//  Time-multiplexed, streaming 6-tap FIR; the sequential counterpart of the fully

---
 rtl/fir_pkg.sv | 10 +
 rtl/fir_delay_line.sv | 25 ++
 rtl/fir_serial_mac.sv | 74 +++++++
 tb/tb_fir_serial_mac.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding, default widths and accumulator width helper
package fir_pkg;
   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
   localparam int DATA_W_D = 16;
   localparam int COEF_W_D = 16;
   localparam int TAPS_D = 6;
   function automatic int acc_w(input int dw, input int cw, input int taps);
      return dw + cw + $clog2(taps);
   endfunction
endpackage

// File: rtl/fir_delay_line.sv
// fir_delay_line: TAPS-deep sample shift register with clear and indexed read port
module fir_delay_line #(
   parameter int DATA_W = 16,
   parameter int TAPS = 6,
   localparam int IDX_W = $clog2(TAPS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_shift,
   input  logic                     i_clr,
   input  logic signed [DATA_W-1:0] i_din,
   input  logic [IDX_W-1:0]         i_idx,
   output logic signed [DATA_W-1:0] o_x
);
   logic signed [DATA_W-1:0] r_x [TAPS];
   always_ff @(posedge clk or posedge rst) begin
      if (rst || i_clr) begin
         for (int k = 0; k < TAPS; k++) r_x[k] <= '0;
      end else if (i_shift) begin
         r_x[0] <= i_din;
         for (int k = 1; k < TAPS; k++) r_x[k] <= r_x[k-1];
      end
   end
   assign o_x = r_x[i_idx];
endmodule

// File: rtl/fir_serial_mac.sv
// fir_serial_mac: streaming TAPS-tap FIR evaluated on one shared multiplier-accumulator
module fir_serial_mac
   import fir_pkg::*;
#(
   parameter int DATA_W = DATA_W_D,
   parameter int COEF_W = COEF_W_D,
   parameter int TAPS = TAPS_D,
   parameter int ACC_W = acc_w(DATA_W, COEF_W, TAPS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [TAPS*COEF_W-1:0]   coef,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ACC_W-1:0]         out_data
);
   localparam int IDX_W = $clog2(TAPS);
   localparam int PW = DATA_W + COEF_W;
   state_t r_state, w_next;
   logic [IDX_W-1:0] r_idx;
   logic signed [COEF_W-1:0] r_coef [TAPS];
   logic signed [ACC_W-1:0] r_acc, r_out, w_sum;
   logic signed [DATA_W-1:0] w_x;
   logic signed [PW-1:0] w_prod;
   logic w_accept, w_clr, w_last;

   fir_delay_line #(.DATA_W(DATA_W), .TAPS(TAPS)) u_dl (
      .clk(clk), .rst(rst), .i_shift(w_accept), .i_clr(w_clr),
      .i_din(in_data), .i_idx(r_idx), .o_x(w_x)
   );

   always_comb begin
      w_clr = (r_state == IDLE) && flush;
      w_accept = (r_state == IDLE) && !flush && in_valid;
      w_last = r_idx == IDX_W'(TAPS - 1);
      w_next = w_accept ? MAC :
               (r_state == MAC && w_last) ? DONE :
               (r_state == DONE && out_ready) ? IDLE : r_state;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else r_state <= w_next;
   end

   // products sign-extend into the accumulator; a narrowed ACC_W wraps modulo 2^ACC_W
   assign w_prod = PW'(w_x) * PW'(r_coef[r_idx]);
   assign w_sum = r_acc + ACC_W'(w_prod);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx <= '0;
         r_acc <= '0;
         r_out <= '0;
         for (int k = 0; k < TAPS; k++) r_coef[k] <= '0;
      end else if (w_accept) begin
         r_idx <= '0;
         r_acc <= '0;
         for (int k = 0; k < TAPS; k++) r_coef[k] <= coef[k*COEF_W +: COEF_W];
      end else if (r_state == MAC) begin
         r_acc <= w_sum;
         r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
         if (w_last) r_out <= w_sum;
      end
   end

   assign in_ready = (r_state == IDLE) && !rst;
   assign out_valid = r_state == DONE;
   assign out_data = r_out;
endmodule

// File: tb/tb_fir_serial_mac.sv
// tb_fir_serial_mac: directed vectors checked against a sum-of-products model every cycle
module tb_fir_serial_mac;
   localparam int TAPS = 6;
   logic clk = 0, rst = 1, in_valid = 0, flush = 0, out_ready = 1;
   logic in_ready, out_valid;
   logic [15:0] in_data = 0;
   logic [95:0] coef;
   logic [34:0] out_data;
   logic signed [15:0] c [TAPS];
   int checks = 0, failures = 0;
   longint h [TAPS];
   longint m_exp = 0;
   bit m_busy = 0;
   int m_cyc = 0;
   longint res_q [$];

   fir_serial_mac dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .coef(coef), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   always #5 clk = ~clk;

   always_comb begin
      coef = '0;
      for (int k = 0; k < TAPS; k++) coef[k*16 +: 16] = c[k];
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: one result per accepted sample, visible TAPS edges after acceptance
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 0;
         m_cyc = 0;
         for (int k = 0; k < TAPS; k++) h[k] = 0;
      end else if (!m_busy) begin
         if (flush) begin
            for (int k = 0; k < TAPS; k++) h[k] = 0;
         end else if (in_valid) begin
            for (int k = TAPS - 1; k > 0; k--) h[k] = h[k-1];
            h[0] = longint'($signed(in_data));
            m_exp = 0;
            for (int k = 0; k < TAPS; k++) m_exp += h[k] * longint'(c[k]);
            m_busy = 1;
            m_cyc = 0;
         end
      end else if (m_cyc >= TAPS && out_ready) m_busy = 0;
      else m_cyc++;
   end

   always @(negedge clk) begin
      check("in_ready", longint'(in_ready), longint'(!m_busy && !rst));
      check("out_valid", longint'(out_valid), longint'(m_busy && m_cyc >= TAPS));
      if (m_busy && m_cyc >= TAPS) check("out_data", longint'($signed(out_data)), m_exp);
   end

   always @(posedge clk) if (!rst && out_valid && out_ready) res_q.push_back(longint'($signed(out_data)));

   task automatic send(input logic signed [15:0] x);
      int n = 0;
      in_data = x;
      in_valid = 1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         if (++n > 200) begin
            check("send_timeout", 1, 0);
            break;
         end
      end
      @(posedge clk);
      #2 in_valid = 0;
   endtask

   task automatic wait_res(input int n);
      int t = 0;
      while (res_q.size() < n && t < 300) begin
         @(posedge clk);
         #1 t++;
      end
      if (res_q.size() < n) check("result_timeout", res_q.size(), n);
   endtask

   task automatic flush_pulse(input logic v);
      int n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #2 flush = 1;
      in_valid = v;
      in_data = 999;
      @(posedge clk);
      #2 flush = 0;
      in_valid = 0;
   endtask

   initial begin
      int lat;
      bit ok;
      longint v;
      for (int k = 0; k < TAPS; k++) c[k] = 16'(k + 1);
      #1;
      check("rst_in_ready", longint'(in_ready), 0);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_out_data", longint'(out_data), 0);
      repeat (3) @(posedge clk);
      #2 rst = 0;
      #1 check("rel_in_ready", longint'(in_ready), 1);

      send(1);
      for (lat = 0; lat < 20; lat++) begin
         if (out_valid) break;
         @(posedge clk);
         #1;
      end
      check("latency", lat, TAPS);
      repeat (6) send(0);
      wait_res(7);
      for (int i = 0; i < 7; i++) check("impulse", res_q[i], (i < 6) ? longint'(i + 1) : 0);
      res_q.delete();

      for (int k = 0; k < TAPS; k++) c[k] = -16'sd32768;
      repeat (6) send(-16'sd32768);
      wait_res(6);
      check("extreme", res_q[5], 64'sd6442450944);
      res_q.delete();

      for (int k = 0; k < TAPS; k++) c[k] = 16'(k + 1);
      out_ready = 0;
      send(3);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         #1 lat++;
      end
      v = longint'($signed(out_data));
      in_valid = 1;
      in_data = 777;
      ok = out_valid;
      repeat (20) begin
         @(posedge clk);
         #1 ok &= out_valid && !in_ready && longint'($signed(out_data)) == v;
      end
      check("stall_stable", longint'(ok), 1);
      in_valid = 0;
      out_ready = 1;
      wait_res(1);
      check("stall_result", res_q[0], v);
      res_q.delete();

      for (int k = 0; k < TAPS; k++) c[k] = 1;
      flush_pulse(0);
      repeat (3) send(100);
      wait_res(3);
      check("pre_flush", res_q[2], 300);
      flush_pulse(1);
      send(5);
      wait_res(4);
      check("flush_wins", res_q[3], 5);
      res_q.delete();

      flush_pulse(0);
      send(10);
      for (int k = 0; k < TAPS; k++) c[k] = 2;
      wait_res(1);
      check("coef_inflight", res_q[0], 10);
      send(20);
      wait_res(2);
      check("coef_next", res_q[1], 60);
      res_q.delete();

      for (int k = 0; k < TAPS; k++) c[k] = 16'(k + 1);
      send(7);
      repeat (2) @(posedge clk);
      #2 rst = 1;
      #1 check("mid_rst_out_valid", longint'(out_valid), 0);
      check("mid_rst_in_ready", longint'(in_ready), 0);
      repeat (2) @(posedge clk);
      #2 rst = 0;
      #1 check("post_rst_in_ready", longint'(in_ready), 1);
      check("post_rst_out_data", longint'(out_data), 0);
      res_q.delete();
      send(1);
      wait_res(1);
      check("post_rst_impulse", res_q[0], 1);
      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
